riscv_multi_ctrl_fsm_hs: RTL and testbench

Parametrised successor to the multi-cycle RV32I controller main FSM. Adds a memory request/ready handshake with variable wait states, a memory timeout, an illegal-opcode trap, and a retired-instruction counter. Sits inside the controller, between the instruction register/datapath and the unified instruction/data memory port. ALU decode stays in the separate ALU decoder, driven by ALUOp.

---
 rtl/riscv_multi_ctrl_fsm_hs.sv | 245 ++++++++++++++++++++++++
 tb/tb_riscv_multi_ctrl_fsm_hs.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/riscv_multi_ctrl_fsm_hs.sv
// riscv_multi_ctrl_fsm_hs
// Main FSM of the multi-cycle RV32I controller with a memory request/ready
// handshake. It supports variable wait states, a memory timeout trap, an
// illegal-opcode trap and a retired-instruction counter.
//
// Parameters
//   CNT_W        width of instret
//   TMO_W        width of the memory wait counter
//   MEM_TIMEOUT  consecutive wait cycles tolerated before the timeout trap
//                (must fit in TMO_W bits)
//
// Ports
//   clk, reset   clock and synchronous active-high reset
//   op           opcode field of the instruction register
//   Zero         ALU zero flag, used by beq
//   mem_ready    memory completes the current request this cycle
//   mem_req      memory access request
//   PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
//   ResultSrc, ALUSrcA, ALUSrcB, ALUOp
//                datapath controls
//   illegal      sticky flag, set when an illegal opcode is trapped
//   timeout      sticky flag, set when a memory timeout is trapped
//   instret      retired instruction count, wraps
//   state        current state encoding, for debug
//
// state | meaning
// ------+-------------------------------------------------
//   0   | FETCH    request instruction, PC += 4 on ready
//   1   | DECODE   oldPC + imm precompute, dispatch on op
//   2   | MEMADR   rs1 + imm address calculation
//   3   | MEMREAD  load request, wait for ready
//   4   | MEMWB    write load data to register file
//   5   | MEMWRITE store request, commits on ready
//   6   | EXECR    R-type ALU operation
//   7   | EXECI    I-type ALU operation
//   8   | ALUWB    write ALU result to register file
//   9   | BEQ      compare, branch when Zero
//  10   | JAL      PC <- target, link through ALUWB
//  15   | TRAP     absorbing until reset
module riscv_multi_ctrl_fsm_hs #(
  parameter int CNT_W       = 32,
  parameter int TMO_W       = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic             illegal,
  output logic             timeout,
  output logic [CNT_W-1:0] instret,
  output logic [3:0]       state
);

  localparam logic [3:0] FETCH    = 4'd0;
  localparam logic [3:0] DECODE   = 4'd1;
  localparam logic [3:0] MEMADR   = 4'd2;
  localparam logic [3:0] MEMREAD  = 4'd3;
  localparam logic [3:0] MEMWB    = 4'd4;
  localparam logic [3:0] MEMWRITE = 4'd5;
  localparam logic [3:0] EXECR    = 4'd6;
  localparam logic [3:0] EXECI    = 4'd7;
  localparam logic [3:0] ALUWB    = 4'd8;
  localparam logic [3:0] BEQ      = 4'd9;
  localparam logic [3:0] JAL      = 4'd10;
  localparam logic [3:0] TRAP     = 4'd15;

  localparam logic [TMO_W-1:0] TMO_LIM  = MEM_TIMEOUT[TMO_W-1:0];
  localparam logic [TMO_W-1:0] WCNT_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = 1;

  logic [TMO_W-1:0] wcnt;
  logic [TMO_W-1:0] wcnt_nxt;
  logic [3:0]       state_nxt;
  logic             set_illegal;
  logic             set_timeout;
  logic             retire;

  logic             mem_req_d;
  logic             pc_write_d;
  logic             mem_write_d;
  logic             ir_write_d;
  logic             reg_write_d;

  // Next-state, wait counter and event logic
  always_comb begin
    state_nxt   = state;
    wcnt_nxt    = '0;
    set_illegal = 1'b0;
    set_timeout = 1'b0;
    retire      = 1'b0;
    case (state)
      FETCH, MEMREAD, MEMWRITE: begin
        if (mem_ready) begin
          // completion wins over a timeout reached in the same cycle
          case (state)
            FETCH:   state_nxt = DECODE;
            MEMREAD: state_nxt = MEMWB;
            default: begin
              state_nxt = FETCH;
              retire    = 1'b1;
            end
          endcase
        end else if (wcnt == TMO_LIM) begin
          state_nxt   = TRAP;
          set_timeout = 1'b1;
        end else begin
          wcnt_nxt = wcnt + WCNT_ONE;
        end
      end
      DECODE: begin
        case (op)
          7'b0000011, 7'b0100011: state_nxt = MEMADR;
          7'b0110011:             state_nxt = EXECR;
          7'b0010011:             state_nxt = EXECI;
          7'b1100011:             state_nxt = BEQ;
          7'b1101111:             state_nxt = JAL;
          default: begin
            state_nxt   = TRAP;
            set_illegal = 1'b1;
          end
        endcase
      end
      MEMADR: state_nxt = op[5] ? MEMWRITE : MEMREAD;
      MEMWB: begin
        state_nxt = FETCH;
        retire    = 1'b1;
      end
      EXECR, EXECI: state_nxt = ALUWB;
      ALUWB, BEQ: begin
        state_nxt = FETCH;
        retire    = 1'b1;
      end
      JAL:  state_nxt = ALUWB;
      TRAP: state_nxt = TRAP;
      default: begin
        state_nxt   = TRAP;
        set_illegal = 1'b1;
      end
    endcase
  end

  // Moore output decode; only IRWrite/PCWrite in FETCH and PCWrite in BEQ
  // depend on inputs
  always_comb begin
    mem_req_d   = 1'b0;
    pc_write_d  = 1'b0;
    mem_write_d = 1'b0;
    ir_write_d  = 1'b0;
    reg_write_d = 1'b0;
    AdrSrc      = 1'b0;
    ResultSrc   = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    case (state)
      FETCH: begin
        mem_req_d  = 1'b1;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        ir_write_d = mem_ready;
        pc_write_d = mem_ready;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      MEMREAD: begin
        mem_req_d = 1'b1;
        AdrSrc    = 1'b1;
      end
      MEMWB: begin
        ResultSrc   = 2'b01;
        reg_write_d = 1'b1;
      end
      MEMWRITE: begin
        // held for the whole request; memory commits on the ready cycle
        mem_req_d   = 1'b1;
        AdrSrc      = 1'b1;
        mem_write_d = 1'b1;
      end
      EXECR: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
      end
      EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
      end
      ALUWB: reg_write_d = 1'b1;
      BEQ: begin
        ALUSrcA    = 2'b10;
        ALUOp      = 2'b01;
        pc_write_d = Zero;
      end
      JAL: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        pc_write_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Enables are suppressed combinationally while reset is asserted so that an
  // in-flight request is dropped immediately rather than one cycle later
  assign mem_req  = mem_req_d   & ~reset;
  assign PCWrite  = pc_write_d  & ~reset;
  assign MemWrite = mem_write_d & ~reset;
  assign IRWrite  = ir_write_d  & ~reset;
  assign RegWrite = reg_write_d & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= FETCH;
      wcnt    <= '0;
      instret <= '0;
      illegal <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
      if (set_illegal) illegal <= 1'b1;
      if (set_timeout) timeout <= 1'b1;
      if (retire)      instret <= instret + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_riscv_multi_ctrl_fsm_hs.sv
// Directed bench for riscv_multi_ctrl_fsm_hs, built with a 4-bit instret
// so that counter wrap is reachable in a short run.
module tb_riscv_multi_ctrl_fsm_hs;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic       Zero;
  logic       mem_ready;
  logic       mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic       illegal, timeout;
  logic [3:0] instret;
  logic [3:0] state;

  int errors = 0;
  int checks = 0;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_SYS = 7'b1110011;

  riscv_multi_ctrl_fsm_hs #(.CNT_W(4), .TMO_W(4), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .op(op), .Zero(Zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .illegal(illegal), .timeout(timeout),
    .instret(instret), .state(state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one R-type instruction from FETCH with zero wait states
  task automatic run_r();
    op = OP_R;
    mem_ready = 1'b1;
    repeat (4) tick();
  endtask

  initial begin
    reset = 1'b1; op = OP_R; Zero = 1'b0; mem_ready = 1'b0;
    tick(); tick();
    chk("rst_state", state, 0);
    chk("rst_enables", {mem_req, PCWrite, IRWrite, RegWrite, MemWrite}, 0);
    chk("rst_instret", instret, 0);
    chk("rst_flags", {illegal, timeout}, 0);
    reset = 1'b0;
    #1;
    chk("fetch_req", {mem_req, AdrSrc, ALUSrcB, ResultSrc}, 6'b1_0_10_10);

    // zero-wait R-type: 0,1,6,8,0
    mem_ready = 1'b1;
    #1;
    chk("fetch_irw_pcw", {IRWrite, PCWrite}, 2'b11);
    tick(); chk("r_s1", state, 1);
    chk("r_decode_src", {ALUSrcA, ALUSrcB, RegWrite}, 5'b01_01_0);
    tick(); chk("r_s6", state, 6);
    chk("r_exec", {ALUSrcA, ALUSrcB, ALUOp, RegWrite}, 7'b10_00_10_0);
    tick(); chk("r_s8", state, 8);
    chk("r_wb", {RegWrite, ResultSrc}, 3'b1_00);
    tick(); chk("r_s0", state, 0);
    chk("r_instret", instret, 1);

    // lw with 3 FETCH waits and 2 MEMREAD waits: 10 cycles
    op = OP_LW; mem_ready = 1'b0;
    #1;
    chk("lw_fetch_wait_irw", IRWrite, 0);
    tick(); chk("lw_w1_irw", IRWrite, 0);
    tick(); tick();
    chk("lw_w3_state", state, 0);
    chk("lw_w3_irw", IRWrite, 0);
    mem_ready = 1'b1;
    #1;
    chk("lw_ready_irw", IRWrite, 1);
    tick(); chk("lw_s1", state, 1);
    chk("lw_decode_irw", IRWrite, 0);
    mem_ready = 1'b0;
    tick(); chk("lw_s2", state, 2);
    tick(); chk("lw_s3", state, 3);
    chk("lw_read_ctl", {mem_req, AdrSrc, ResultSrc, MemWrite}, 5'b1_1_00_0);
    tick(); tick(); chk("lw_s3_wait", state, 3);
    mem_ready = 1'b1;
    tick(); chk("lw_s4", state, 4);
    chk("lw_wb", {RegWrite, ResultSrc}, 3'b1_01);
    tick(); chk("lw_s0", state, 0);
    chk("lw_instret", instret, 2);
    chk("lw_timeout", timeout, 0);

    // ready arrives on the 16th wait cycle: completion wins
    mem_ready = 1'b0; op = OP_R;
    repeat (15) tick();
    chk("tmo_edge_state", state, 0);
    mem_ready = 1'b1;
    tick(); chk("tmo_edge_decode", state, 1);
    chk("tmo_edge_flag", timeout, 0);
    tick(); tick(); tick();
    chk("tmo_edge_instret", instret, 3);

    // 16 wait cycles: timeout trap
    mem_ready = 1'b0;
    repeat (15) tick();
    chk("tmo_pre_state", state, 0);
    tick(); chk("tmo_state", state, 15);
    chk("tmo_flag", timeout, 1);
    chk("tmo_enables", {mem_req, PCWrite, IRWrite, RegWrite, MemWrite}, 0);

    reset = 1'b1;
    tick();
    chk("rst2", {state, instret, illegal, timeout}, 0);
    reset = 1'b0;

    // beq taken and not taken
    op = OP_BEQ; mem_ready = 1'b1; Zero = 1'b1;
    tick(); tick();
    chk("beq_s9", state, 9);
    chk("beq_taken", {PCWrite, ALUOp, ALUSrcA, ALUSrcB}, 7'b1_01_10_00);
    tick(); chk("beq_t_instret", instret, 1);
    Zero = 1'b0;
    tick(); tick();
    chk("beq_nt", {state, PCWrite}, {4'd9, 1'b0});
    tick(); chk("beq_nt_instret", instret, 2);

    // jal retires once through ALUWB
    op = OP_JAL;
    tick(); tick();
    chk("jal_s10", {state, PCWrite, ALUSrcA, ALUSrcB}, {4'd10, 1'b1, 2'b01, 2'b10});
    tick(); chk("jal_s8", {state, instret}, {4'd8, 4'd2});
    tick(); chk("jal_instret", {state, instret}, {4'd0, 4'd3});

    // sw with 2 wait cycles holds MemWrite for 3 cycles
    op = OP_SW;
    tick(); tick();
    chk("sw_s2", state, 2);
    mem_ready = 1'b0;
    tick(); chk("sw_c1", {state, MemWrite, mem_req, AdrSrc}, {4'd5, 3'b111});
    tick(); chk("sw_c2", {state, MemWrite}, {4'd5, 1'b1});
    tick(); chk("sw_c3", {state, MemWrite}, {4'd5, 1'b1});
    mem_ready = 1'b1;
    tick(); chk("sw_done", {state, instret}, {4'd0, 4'd4});

    // counter wrap with a 4-bit instret
    reset = 1'b1; tick(); reset = 1'b0;
    repeat (16) run_r();
    chk("wrap_16", instret, 0);
    run_r();
    chk("wrap_17", instret, 1);

    // illegal opcode traps and holds all enables low
    op = OP_SYS; mem_ready = 1'b1;
    tick(); chk("ill_decode", state, 1);
    tick(); chk("ill_state", {state, illegal}, {4'd15, 1'b1});
    for (int i = 0; i < 20; i++) begin
      mem_ready = i[0];
      Zero = i[1];
      tick();
      chk("ill_hold", {state, mem_req, PCWrite, IRWrite, RegWrite, MemWrite}, {4'd15, 5'b0});
    end

    // reset in the middle of a load request
    reset = 1'b1; tick(); reset = 1'b0;
    op = OP_LW; mem_ready = 1'b1;
    tick(); tick(); tick();
    mem_ready = 1'b0;
    chk("mid_s3", {state, mem_req}, {4'd3, 1'b1});
    reset = 1'b1;
    #1;
    chk("mid_rst_req", mem_req, 0);
    tick();
    chk("mid_rst", {state, instret, illegal, timeout}, 0);
    chk("mid_rst_req2", {mem_req, IRWrite}, 0);
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
